// File: rtl/hdc_pkg.sv
// Shared HDC constants, index types and the class-HV binarization rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hdc_pkg;

  localparam int HV_DIM      = 4096;
  localparam int DIMS_PER_CC = 1024;
  localparam int NUM_CHUNKS  = HV_DIM / DIMS_PER_CC;
  localparam int NUM_CLASSES = 26;
  localparam int CTR_W       = 8;
  localparam int SCNT_W      = 12;
  localparam int CLS_W       = 5;
  localparam int CHK_W       = $clog2(NUM_CHUNKS);

  typedef logic [CLS_W-1:0]                  class_id_t;
  typedef logic [CHK_W-1:0]                  chunk_idx_t;
  typedef logic [SCNT_W-1:0]                 scnt_t;
  typedef logic [DIMS_PER_CC-1:0][CTR_W-1:0] ctr_row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIN   = 2'd2
  } accum_state_e;

  localparam class_id_t  LAST_CLASS = class_id_t'(NUM_CLASSES - 1);
  localparam chunk_idx_t LAST_CHUNK = chunk_idx_t'(NUM_CHUNKS - 1);

  // Majority bit: set only when the dimension was hit in strictly more than
  // half of the samples. 2*ctr is widened to the sample-count width so a
  // saturated counter can never wrap into a false 0.
  function automatic logic bin_bit(input logic [CTR_W-1:0] ctr, input scnt_t scnt);
    scnt_t dbl;
    dbl = SCNT_W'({ctr, 1'b0});
    return dbl > scnt;
  endfunction

endpackage

// File: rtl/class_ctr_row_update.sv
// Adds one encoded-HV chunk into one row of saturating per-dimension counters.
// Latency: combinational; the parent registers the result on the next edge.
// Backpressure: none, the parent presents exactly one row per accumulate cycle.
module class_ctr_row_update
  import hdc_pkg::*;
(
  input  ctr_row_t               i_row,
  input  logic [DIMS_PER_CC-1:0] i_bits,
  output ctr_row_t               o_row
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  // Increment each counter whose bit is set, holding at all-ones instead of wrapping
  always_comb begin
    o_row = i_row;
    for (int d = 0; d < DIMS_PER_CC; d++) begin
      if (i_bits[d] && (i_row[d] != CTR_MAX)) begin
        o_row[d] = i_row[d] + CTR_ONE;
      end
    end
  end

endmodule

// File: rtl/class_hv_accum.sv
// Class HV accumulator: sums encoded-HV chunks per class, then binarizes all classes out.
// Latency: start -> accum_done 4 cycles; binarized chunk valid the cycle after bin_start.
// Backpressure: readout holds chunk/class/idx stable while cls_hv_valid & !cls_hv_ready.
module class_hv_accum
  import hdc_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   train_en,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CLS_W-1:0]       class_id,
  input  logic [DIMS_PER_CC-1:0] input_hv_chunk,
  output logic [CHK_W-1:0]       nonbin_ctr,
  output logic                   busy,
  output logic                   accum_done,
  output logic                   id_err,
  input  logic                   bin_start,
  output logic [DIMS_PER_CC-1:0] cls_hv_chunk,
  output logic                   cls_hv_valid,
  input  logic                   cls_hv_ready,
  output logic [CLS_W-1:0]       cls_hv_class,
  output logic [CHK_W-1:0]       cls_hv_idx,
  output logic                   bin_done
);

  accum_state_e r_state;
  class_id_t    r_cls;       // accumulate target, or readout class
  chunk_idx_t   r_k;         // accumulate chunk, or readout chunk
  logic         r_accum_done;
  logic         r_id_err;

  ctr_row_t r_ctr  [NUM_CLASSES][NUM_CHUNKS];
  scnt_t    r_scnt [NUM_CLASSES];

  ctr_row_t                 w_row_rd;
  ctr_row_t                 w_row_upd;
  logic                     w_idle;
  logic                     w_clr;
  logic                     w_start;
  logic                     w_go_accum;
  logic                     w_bad_id;
  logic                     w_go_bin;
  logic                     w_accept;
  logic                     w_last;
  logic [DIMS_PER_CC-1:0]   w_bin_chunk;

  // Request arbitration in IDLE: clr beats start beats bin_start, losers are dropped
  assign w_idle     = (r_state == IDLE);
  assign w_clr      = w_idle & clr;
  assign w_start    = w_idle & ~clr & start & train_en;
  assign w_go_accum = w_start & (class_id <= LAST_CLASS);
  assign w_bad_id   = w_start & (class_id > LAST_CLASS);
  assign w_go_bin   = w_idle & ~clr & ~w_start & bin_start;
  assign w_accept   = (r_state == BIN) & cls_hv_ready;
  assign w_last     = (r_cls == LAST_CLASS) & (r_k == LAST_CHUNK);

  // One row is read per cycle; accumulate and readout never overlap so they share it
  assign w_row_rd = r_ctr[r_cls][r_k];

  class_ctr_row_update u_row_update (
    .i_row  (w_row_rd),
    .i_bits (input_hv_chunk),
    .o_row  (w_row_upd)
  );

  // Control FSM: IDLE arbitration, 4-chunk accumulate walk, class-major readout walk
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_cls        <= '0;
      r_k          <= '0;
      r_accum_done <= 1'b0;
      r_id_err     <= 1'b0;
    end else begin
      r_accum_done <= 1'b0;
      r_id_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go_accum) begin
            r_state <= ACCUM;
            r_cls   <= class_id;
            r_k     <= '0;
          end else if (w_bad_id) begin
            r_id_err <= 1'b1;
          end else if (w_go_bin) begin
            r_state <= BIN;
            r_cls   <= '0;
            r_k     <= '0;
          end
        end
        ACCUM: begin
          // train_en is deliberately not looked at: a started sample always completes
          r_k <= r_k + chunk_idx_t'(1);
          if (r_k == LAST_CHUNK) begin
            r_state      <= IDLE;
            r_cls        <= '0;
            r_accum_done <= 1'b1;
          end
        end
        BIN: begin
          if (w_accept) begin
            r_k <= r_k + chunk_idx_t'(1);
            if (w_last) begin
              r_state <= IDLE;
              r_cls   <= '0;
            end else if (r_k == LAST_CHUNK) begin
              r_cls <= r_cls + class_id_t'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Counter and sample-count storage: bulk clear, or one row written per accumulate cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          r_ctr[c][k] <= '0;
        end
        r_scnt[c] <= '0;
      end
    end else if (w_clr) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          r_ctr[c][k] <= '0;
        end
        r_scnt[c] <= '0;
      end
    end else if (r_state == ACCUM) begin
      r_ctr[r_cls][r_k] <= w_row_upd;
      if ((r_k == LAST_CHUNK) && (r_scnt[r_cls] != '1)) begin
        r_scnt[r_cls] <= r_scnt[r_cls] + scnt_t'(1);
      end
    end
  end

  // Binarize the addressed row; forced to zero whenever no readout is in flight
  always_comb begin
    w_bin_chunk = '0;
    if (r_state == BIN) begin
      for (int d = 0; d < DIMS_PER_CC; d++) begin
        w_bin_chunk[d] = bin_bit(w_row_rd[d], r_scnt[r_cls]);
      end
    end
  end

  assign busy         = ~w_idle;
  assign nonbin_ctr   = (r_state == ACCUM) ? r_k : '0;
  assign accum_done   = r_accum_done;
  assign id_err       = r_id_err;
  assign cls_hv_valid = (r_state == BIN);
  assign cls_hv_chunk = w_bin_chunk;
  assign cls_hv_class = cls_hv_valid ? r_cls : '0;
  assign cls_hv_idx   = cls_hv_valid ? r_k : '0;
  assign bin_done     = w_accept & w_last;

endmodule

// File: tb/tb_class_hv_accum.sv
// Randomized bench for class_hv_accum with an arithmetic reference model and readout scoreboard.
// Latency: n/a.
// Backpressure: randomly toggles cls_hv_ready during some readouts.
`timescale 1ns/1ps
module tb_class_hv_accum;
  import hdc_pkg::*;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   train_en = 1'b0;
  logic                   clr = 1'b0;
  logic                   start = 1'b0;
  logic [CLS_W-1:0]       class_id = '0;
  logic [DIMS_PER_CC-1:0] input_hv_chunk;
  logic [CHK_W-1:0]       nonbin_ctr;
  logic                   busy;
  logic                   accum_done;
  logic                   id_err;
  logic                   bin_start = 1'b0;
  logic [DIMS_PER_CC-1:0] cls_hv_chunk;
  logic                   cls_hv_valid;
  logic                   cls_hv_ready = 1'b0;
  logic [CLS_W-1:0]       cls_hv_class;
  logic [CHK_W-1:0]       cls_hv_idx;
  logic                   bin_done;

  logic [HV_DIM-1:0] cur_hv = '0;

  always #5 clk = ~clk;

  // Behaves like the upstream mux: chunk selected combinationally by nonbin_ctr
  assign input_hv_chunk = cur_hv[int'(nonbin_ctr)*DIMS_PER_CC +: DIMS_PER_CC];

  class_hv_accum dut (
    .clk            (clk),
    .nrst           (nrst),
    .train_en       (train_en),
    .clr            (clr),
    .start          (start),
    .class_id       (class_id),
    .input_hv_chunk (input_hv_chunk),
    .nonbin_ctr     (nonbin_ctr),
    .busy           (busy),
    .accum_done     (accum_done),
    .id_err         (id_err),
    .bin_start      (bin_start),
    .cls_hv_chunk   (cls_hv_chunk),
    .cls_hv_valid   (cls_hv_valid),
    .cls_hv_ready   (cls_hv_ready),
    .cls_hv_class   (cls_hv_class),
    .cls_hv_idx     (cls_hv_idx),
    .bin_done       (bin_done)
  );

  // Reference model: plain per-dimension hit counts and per-class sample counts
  int m_ctr  [NUM_CLASSES][HV_DIM];
  int m_scnt [NUM_CLASSES];

  typedef struct {
    int                     cls;
    int                     idx;
    logic [DIMS_PER_CC-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  bit in_bin = 1'b0;
  bit stall_prev = 1'b0;
  logic [DIMS_PER_CC-1:0] h_dat;
  logic [CLS_W-1:0]       h_cls;
  logic [CHK_W-1:0]       h_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_chunk(input string name, input logic [DIMS_PER_CC-1:0] act,
                           input logic [DIMS_PER_CC-1:0] expv);
    int nd;
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      nd = $countones(act ^ expv);
      $display("FAIL %s: %0d bits differ, got[63:0]=%h expected[63:0]=%h (t=%0t)",
               name, nd, act[63:0], expv[63:0], $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int i = 0; i < HV_DIM; i++) m_ctr[c][i] = 0;
      m_scnt[c] = 0;
    end
  endtask

  task automatic model_add(input int cls, input logic [HV_DIM-1:0] hv);
    for (int i = 0; i < HV_DIM; i++) begin
      if (hv[i] && (m_ctr[cls][i] < (1 << CTR_W) - 1)) m_ctr[cls][i]++;
    end
    if (m_scnt[cls] < (1 << SCNT_W) - 1) m_scnt[cls]++;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},       busy,         0);
    chk({tag, "_nonbin"},     nonbin_ctr,   0);
    chk({tag, "_accum_done"}, accum_done,   0);
    chk({tag, "_id_err"},     id_err,       0);
    chk({tag, "_valid"},      cls_hv_valid, 0);
    chk({tag, "_class"},      cls_hv_class, 0);
    chk({tag, "_idx"},        cls_hv_idx,   0);
    chk({tag, "_bin_done"},   bin_done,     0);
    chk_chunk({tag, "_chunk"}, cls_hv_chunk, '0);
  endtask

  function automatic logic [HV_DIM-1:0] rand_hv();
    logic [HV_DIM-1:0] v;
    for (int w = 0; w < HV_DIM / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  // One sample: start, walk 4 chunks, expect accum_done exactly 4 cycles later
  task automatic issue_sample(input int cls, input logic [HV_DIM-1:0] hv,
                              input bit with_bin, input bit drop_train);
    cur_hv    = hv;
    class_id  = CLS_W'(cls);
    start     = 1'b1;
    bin_start = with_bin;
    @(posedge clk); #1;
    start     = 1'b0;
    bin_start = 1'b0;
    if (drop_train) train_en = 1'b0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      chk("accum_nonbin", nonbin_ctr, k);
      chk("accum_busy", busy, 1);
      chk("accum_done_early", accum_done, 0);
      if (with_bin) chk("accum_no_readout", cls_hv_valid, 0);
      @(posedge clk); #1;
    end
    chk("accum_done", accum_done, 1);
    chk("accum_back_idle", busy, 0);
    train_en = 1'b1;
    model_add(cls, hv);
  endtask

  // Full readout: expected chunks go to the scoreboard, the monitor compares them
  task automatic run_bin(input bit rand_ready);
    int accepts;
    int cyc;
    bit got;
    accepts = 0;
    cyc = 0;
    got = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        exp_t x;
        x.cls = c;
        x.idx = k;
        for (int d = 0; d < DIMS_PER_CC; d++)
          x.dat[d] = (2 * m_ctr[c][k*DIMS_PER_CC + d] > m_scnt[c]);
        exp_q.push_back(x);
      end
    end
    bin_start = 1'b1;
    @(posedge clk); #1;
    bin_start = 1'b0;
    in_bin = 1'b1;
    while (!got && cyc < 2000) begin
      cls_hv_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (cls_hv_valid && cls_hv_ready) accepts++;
      if (bin_done) got = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    in_bin = 1'b0;
    cls_hv_ready = 1'b0;
    chk("bin_done_seen", got, 1);
    chk("bin_accepts", accepts, NUM_CLASSES * NUM_CHUNKS);
    chk("bin_queue_drained", exp_q.size(), 0);
    chk("bin_back_idle", busy, 0);
    chk("bin_valid_low", cls_hv_valid, 0);
    exp_q.delete();
  endtask

  // Monitor: hold-while-stalled, gap-free valid, and in-order scoreboard compare
  always @(negedge clk) begin
    if (!nrst) begin
      stall_prev = 1'b0;
    end else begin
      if (in_bin) chk("gap_free_valid", cls_hv_valid, 1);
      if (stall_prev) begin
        chk_chunk("stall_hold_data", cls_hv_chunk, h_dat);
        chk("stall_hold_class", cls_hv_class, h_cls);
        chk("stall_hold_idx", cls_hv_idx, h_idx);
      end
      stall_prev = cls_hv_valid && !cls_hv_ready;
      h_dat = cls_hv_chunk;
      h_cls = cls_hv_class;
      h_idx = cls_hv_idx;
      if (!cls_hv_valid) chk_chunk("chunk_zero_when_invalid", cls_hv_chunk, '0);
      if (cls_hv_valid && cls_hv_ready) begin
        chk("accept_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rd_class", cls_hv_class, mon_e.cls);
          chk("rd_idx", cls_hv_idx, mon_e.idx);
          chk_chunk("rd_data", cls_hv_chunk, mon_e.dat);
          chk("rd_bin_done", bin_done, exp_q.size() == 0);
        end
      end else begin
        chk("bin_done_spurious", bin_done, 0);
      end
    end
  end

  logic [HV_DIM-1:0] hv_a;
  logic [HV_DIM-1:0] hv_b;
  logic [HV_DIM-1:0] hv_r;

  initial begin
    model_clear();
    nrst = 1'b0;
    train_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("in_reset");
    nrst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("after_reset");

    // All-ones sample to class 3 (timing checked inside issue_sample)
    issue_sample(3, '1, 1'b0, 1'b0);

    // A, A, B to class 0; train_en drops during the last one
    hv_a = rand_hv();
    hv_b = hv_a ^ rand_hv();
    hv_b[5] = ~hv_a[5];
    issue_sample(0, hv_a, 1'b0, 1'b0);
    issue_sample(0, hv_a, 1'b0, 1'b0);
    issue_sample(0, hv_b, 1'b0, 1'b1);
    run_bin(1'b0);

    // Saturation: 300 all-ones samples into class 1
    repeat (300) issue_sample(1, '1, 1'b0, 1'b0);
    run_bin(1'b1);

    // Out-of-range class ids are rejected with a single-cycle id_err
    for (int v = NUM_CLASSES; v < 32; v += 5) begin
      class_id = CLS_W'(v);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("id_err_pulse", id_err, 1);
      chk("id_err_stays_idle", busy, 0);
      chk("id_err_nonbin", nonbin_ctr, 0);
      @(posedge clk); #1;
      chk("id_err_one_cycle", id_err, 0);
    end

    // start without train_en does nothing
    train_en = 1'b0;
    class_id = CLS_W'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    train_en = 1'b1;
    chk("no_train_ignored", busy, 0);
    chk("no_train_no_err", id_err, 0);

    // start and bin_start together: only the accumulate happens
    hv_r = rand_hv();
    issue_sample(2, hv_r, 1'b1, 1'b0);
    chk("dual_req_no_readout", cls_hv_valid, 0);

    // clr beats start and wipes everything
    clr = 1'b1;
    start = 1'b1;
    class_id = CLS_W'(4);
    @(posedge clk); #1;
    clr = 1'b0;
    start = 1'b0;
    chk("clr_beats_start", busy, 0);
    model_clear();
    run_bin(1'b1);

    // Reset during chunk 2 of an accumulate aborts and clears all state
    issue_sample(5, '1, 1'b0, 1'b0);
    cur_hv = rand_hv();
    class_id = CLS_W'(6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_chunk2", nonbin_ctr, 2);
    #2;
    nrst = 1'b0;
    #1;
    chk_quiet("mid_accum_reset");
    model_clear();
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("post_abort");
    run_bin(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
